// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's pipeline and instruction-SRAM signals.
// The master modport is the fetch stage and the slave modport is its environment.
interface if_fetch_if #(
    parameter int CNT_WD = 32
);
    logic [5:0]        stall;
    logic [32:0]       br_bus;
    logic [32:0]       if_to_id_bus;
    logic              inst_sram_en;
    logic [3:0]        inst_sram_wen;
    logic [31:0]       inst_sram_addr;
    logic [31:0]       inst_sram_wdata;
    logic              fetch_excp;
    logic [31:0]       fetch_badvaddr;
    logic [CNT_WD-1:0] fetch_count;

    modport master (
        input  stall, br_bus,
        output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, fetch_excp, fetch_badvaddr, fetch_count
    );

    modport slave (
        output stall, br_bus,
        input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
               inst_sram_wdata, fetch_excp, fetch_badvaddr, fetch_count
    );
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: PC register, SRAM read port and a one-entry
// pending-redirect buffer that remembers a branch while the PC is held.
module if_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int          CNT_WD       = 32
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    logic [31:0]       r_pc;
    logic              r_ce;
    logic              r_pend_v;
    logic [31:0]       r_pend_addr;
    logic [CNT_WD-1:0] r_cnt;

    logic              w_pc_stop;
    logic              w_id_stop;
    logic              w_br_e;
    logic [31:0]       w_br_addr;
    logic [31:0]       w_next_pc;
    logic              w_fetch_excp;
    logic              w_sram_en;
    logic              w_stall_unused;

    assign w_pc_stop      = bus.stall[0];
    assign w_id_stop      = bus.stall[1];
    assign w_stall_unused = ^bus.stall[5:2];
    assign w_br_e         = bus.br_bus[32];
    assign w_br_addr      = bus.br_bus[31:0];

    // Next-PC priority: buffered redirect, then live redirect, then sequential.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (r_pend_v) begin
            w_next_pc = r_pend_addr;
        end else if (w_br_e) begin
            w_next_pc = w_br_addr;
        end else begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    assign w_fetch_excp = r_ce & (r_pc[1:0] != 2'b00);
    // Enable drops during a hold so the SRAM keeps presenting the held instruction.
    assign w_sram_en    = r_ce & ~w_pc_stop & ~w_fetch_excp;

    // PC, valid flag and pending-redirect buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VECTOR - 32'd4;
            r_ce        <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'h0000_0000;
        end else if (!w_pc_stop) begin
            r_pc     <= w_next_pc;
            r_ce     <= 1'b1;
            r_pend_v <= 1'b0;
        end else if (w_br_e && !w_id_stop && !r_pend_v) begin
            // Decode moves on while we are frozen, so the branch must be kept here.
            r_pend_v    <= 1'b1;
            r_pend_addr <= w_br_addr;
        end else begin
            r_pend_v    <= r_pend_v;
            r_pend_addr <= r_pend_addr;
        end
    end

    // Issued-fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_sram_en) begin
            r_cnt <= r_cnt + {{(CNT_WD-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign bus.if_to_id_bus    = {r_ce, r_pc};
    assign bus.inst_sram_en    = w_sram_en;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = r_pc;
    assign bus.inst_sram_wdata = 32'h0000_0000;
    assign bus.fetch_excp      = w_fetch_excp;
    assign bus.fetch_badvaddr  = w_fetch_excp ? r_pc : 32'h0000_0000;
    assign bus.fetch_count     = r_cnt;
endmodule
